fmap2_stream_out: RTL and testbench

Sequential reader for the second conv layer's output feature map. It snapshots the full CHANNELS x ROWS x COLS output array on request, then streams one pixel per accepted beat over a valid/ready interface. Each beat carries channel/row/column tags and end-of-row and end-of-frame flags. It sits between the combinational conv layer 2 output and the downstream pooling/FC stage, or a debug readout.

---
 rtl/fmap2_stream_out.sv | 143 ++++++++++++++
 tb/tb_fmap2_stream_out.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fmap2_stream_out.sv
// Snapshots the conv layer 2 feature map, then streams it one pixel per beat, channel-major.
// Latency: first beat valid the cycle after capture; frame_done pulses the cycle after the last beat is accepted.
// Backpressure: valid/ready; with m_ready low, every m_* output holds and there is no timeout.
module fmap2_stream_out #(
  parameter int BITWIDTH = 16,
  parameter int CHANNELS = 2,
  parameter int ROWS     = 10,
  parameter int COLS     = 10,
  parameter int RELU     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [BITWIDTH-1:0] featuremap2 [CHANNELS-1:0][ROWS-1:0][COLS-1:0],
  input  logic                       capture_req,
  output logic                       busy,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [BITWIDTH-1:0] m_data,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] m_chan,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]         m_row,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0]         m_col,
  output logic                       m_last_col,
  output logic                       m_last,
  output logic                       frame_done
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] CHAN_MAX = CW'(CHANNELS - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
  localparam logic [KW-1:0] COL_MAX  = KW'(COLS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_q, state_d;
  logic   cap, xfer;
  logic [CW-1:0] nchan;
  logic [RW-1:0] nrow;
  logic [KW-1:0] ncol;
  logic signed [BITWIDTH-1:0] buffer [CHANNELS-1:0][ROWS-1:0][COLS-1:0];

  function automatic logic signed [BITWIDTH-1:0] clamp(input logic signed [BITWIDTH-1:0] v);
    return ((RELU != 0) && v[BITWIDTH-1]) ? '0 : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_req) begin
          cap     = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (m_ready) begin
          xfer = 1'b1;
          if (m_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_valid = (state_q == STREAM);
  assign busy    = (state_q == STREAM);

  // Column fastest, then row, then channel.
  always_comb begin
    nchan = m_chan;
    nrow  = m_row;
    ncol  = m_col;
    if (m_col == COL_MAX) begin
      ncol = '0;
      if (m_row == ROW_MAX) begin
        nrow  = '0;
        nchan = m_chan + 1'b1;
      end else begin
        nrow = m_row + 1'b1;
      end
    end else begin
      ncol = m_col + 1'b1;
    end
  end

  // Snapshot storage needs no reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < COLS; k++)
            buffer[c][r][k] <= clamp(featuremap2[c][r][k]);
    end
  end

  // Beat 0 is taken straight from the input so it is valid the cycle after capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data     <= '0;
      m_chan     <= '0;
      m_row      <= '0;
      m_col      <= '0;
      m_last_col <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer && m_last;
      if (cap) begin
        m_data     <= clamp(featuremap2[0][0][0]);
        m_chan     <= '0;
        m_row      <= '0;
        m_col      <= '0;
        m_last_col <= (COLS == 1);
        m_last     <= (CHANNELS == 1) && (ROWS == 1) && (COLS == 1);
      end else if (xfer) begin
        if (m_last) begin
          m_data     <= '0;
          m_chan     <= '0;
          m_row      <= '0;
          m_col      <= '0;
          m_last_col <= 1'b0;
          m_last     <= 1'b0;
        end else begin
          m_data     <= buffer[nchan][nrow][ncol];
          m_chan     <= nchan;
          m_row      <= nrow;
          m_col      <= ncol;
          m_last_col <= (ncol == COL_MAX);
          m_last     <= (nchan == CHAN_MAX) && (nrow == ROW_MAX) && (ncol == COL_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_fmap2_stream_out.sv
// Bench for fmap2_stream_out: a pass-through and a ReLU instance in lockstep, checked against a
// snapshot-and-index reference model under random backpressure, capture interference and mid-frame reset.
module tb_fmap2_stream_out;

  localparam int N = 200;

  logic clk = 1'b0;
  logic rst;
  logic capture_req;
  logic m_ready;
  logic signed [15:0] fmap [1:0][9:0][9:0];
  logic signed [15:0] snap [1:0][9:0][9:0];

  logic        busy, m_valid, m_last_col, m_last, frame_done;
  logic signed [15:0] m_data;
  logic [0:0]  m_chan;
  logic [3:0]  m_row, m_col;

  logic        r_busy, r_valid, r_last_col, r_last, r_done;
  logic signed [15:0] r_data;
  logic [0:0]  r_chan;
  logic [3:0]  r_row, r_col;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fmap2_stream_out #(.RELU(0)) dut (
    .clk(clk), .rst(rst), .featuremap2(fmap), .capture_req(capture_req),
    .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_chan(m_chan), .m_row(m_row), .m_col(m_col),
    .m_last_col(m_last_col), .m_last(m_last), .frame_done(frame_done)
  );

  fmap2_stream_out #(.RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .featuremap2(fmap), .capture_req(capture_req),
    .busy(r_busy), .m_valid(r_valid), .m_ready(m_ready), .m_data(r_data),
    .m_chan(r_chan), .m_row(r_row), .m_col(r_col),
    .m_last_col(r_last_col), .m_last(r_last), .frame_done(r_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(m_valid), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_data"},  int'(m_data), 0);
    chk({tag, "_done"},  int'(frame_done), 0);
    chk({tag, "_rvalid"}, int'(r_valid), 0);
  endtask

  task automatic fill_ramp();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 10; r++)
        for (int k = 0; k < 10; k++)
          fmap[c][r][k] = 16'(c * 100 + r * 10 + k);
  endtask

  task automatic fill_random();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 10; r++)
        for (int k = 0; k < 10; k++)
          fmap[c][r][k] = 16'($urandom);
  endtask

  // Called at a negedge with the DUT idle. Beat n maps to (n/100, (n/10)%10, n%10).
  task automatic run_frame(input int rdy_pct, input int disturb_at, input int abort_at, input bit chain);
    int beat, cycles, ec, er, ek, ev;
    snap = fmap;
    capture_req = 1'b1;
    @(negedge clk);
    beat = 0;
    cycles = 0;
    while (beat < N && cycles < 5000) begin
      capture_req = 1'b0;
      ec = beat / 100;
      er = (beat / 10) % 10;
      ek = beat % 10;
      ev = int'(snap[ec][er][ek]);
      chk("valid", int'(m_valid), 1);
      chk("busy", int'(busy), 1);
      chk("data", int'(m_data), ev);
      chk("chan", int'(m_chan), ec);
      chk("row", int'(m_row), er);
      chk("col", int'(m_col), ek);
      chk("last_col", int'(m_last_col), int'(ek == 9));
      chk("last", int'(m_last), int'(beat == N - 1));
      chk("done_early", int'(frame_done), 0);
      chk("relu_data", int'(r_data), (ev < 0) ? 0 : ev);
      chk("relu_last", int'(r_last), int'(beat == N - 1));
      if (beat == disturb_at) begin
        for (int c = 0; c < 2; c++)
          for (int r = 0; r < 10; r++)
            for (int k = 0; k < 10; k++)
              fmap[c][r][k] = 16'h7FFF;
        capture_req = 1'b1;
      end
      if (beat == abort_at) begin
        #2 rst = 1'b1;
        #1 chk_idle("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk_idle("post_abort");
        end
        return;
      end
      m_ready = ($urandom_range(99) < rdy_pct);
      if (m_ready) beat++;
      @(negedge clk);
      cycles++;
    end
    capture_req = 1'b0;
    chk("beats", beat, N);
    chk("done", int'(frame_done), 1);
    chk("relu_done", int'(r_done), 1);
    chk("valid_end", int'(m_valid), 0);
    chk("busy_end", int'(busy), 0);
    if (chain) return;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("done_once", int'(frame_done), 0);
      chk("no_restart", int'(m_valid), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    capture_req = 1'b0;
    m_ready = 1'b0;
    fill_ramp();
    #3 chk_idle("reset");
    #9 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("idle");
    end

    // Ramp at full rate, then a back-to-back backpressured ramp after the 1-cycle gap.
    fill_ramp();
    run_frame(100, -1, -1, 1'b1);
    run_frame(50, -1, -1, 1'b0);

    // New input and a capture request mid-frame must not disturb the stream.
    fill_ramp();
    run_frame(100, 50, -1, 1'b0);

    // Negative pixel for the ReLU instance.
    fill_ramp();
    fmap[0][0][0] = -16'sd5;
    fmap[0][0][1] = 16'sd7;
    run_frame(70, -1, -1, 1'b0);

    // Random data, reset at beat 57, then a fresh frame.
    fill_random();
    run_frame(60, -1, 57, 1'b0);
    fill_random();
    run_frame(80, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
